// File: rtl/uart_baud_gen_frac_if.sv
// Control/status bundle for the fractional baud generator: divisor programming,
// run control and the oversample/bit tick outputs.
interface uart_baud_gen_frac_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
);
    logic              enable;
    logic              align_half;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              tick_os;
    logic              tick_bit;
    logic              div_pending;

    modport master (
        output enable, align_half, div_int, div_frac, div_load,
        input  tick_os, tick_bit, div_pending
    );

    modport slave (
        input  enable, align_half, div_int, div_frac, div_load,
        output tick_os, tick_bit, div_pending
    );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Fractional-divisor baud generator: oversample tick every div_int(+carry) clocks,
// bit tick every OS oversample ticks, optional half-bit first tick, shadowed divisor.
module uart_baud_gen_frac #(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4,
    parameter int unsigned OS           = 16,
    parameter int unsigned DIV_INT_RST  = 6,
    parameter int unsigned DIV_FRAC_RST = 13
) (
    input  logic                clock,
    input  logic                reset,
    uart_baud_gen_frac_if.slave bus
);
    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned OS_W  = (OS > 2) ? $clog2(OS) : 1;
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OS - 1);
    localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OS / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    typedef enum logic [1:0] {ST_IDLE, ST_HALF, ST_FULL} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [OS_W-1:0]   os_cnt;
    logic [FRAC_W-1:0] acc;
    logic              carry;
    logic [DIV_W-1:0]  shadow_int;
    logic [FRAC_W-1:0] shadow_frac;
    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic              tick_os_q;
    logic              tick_bit_q;
    logic              pending;
    logic              upd;

    logic [CNT_W-1:0]  period_c;
    logic [OS_W-1:0]   target_c;
    logic              os_fire_c;
    logic              bit_fire_c;
    logic [FRAC_W:0]   acc_sum_c;
    logic [DIV_W-1:0]  load_int_c;

    // Tick decisions and alignment FSM next-state
    always_comb begin
        state_nxt  = state;
        period_c   = CNT_W'(act_int) + CNT_W'(carry);
        target_c   = OS_LAST;
        acc_sum_c  = {1'b0, acc} + {1'b0, act_frac};
        load_int_c = (bus.div_int < DIV_MIN) ? DIV_MIN : bus.div_int;
        if (state == ST_HALF) begin
            target_c = OS_HALF;
        end
        os_fire_c  = bus.enable && (state != ST_IDLE) && (cnt >= period_c);
        bit_fire_c = os_fire_c && (os_cnt == target_c);
        case (state)
            ST_IDLE: if (bus.enable) state_nxt = bus.align_half ? ST_HALF : ST_FULL;
            ST_HALF: if (bit_fire_c) state_nxt = ST_FULL;
            default: ;
        endcase
        if (!bus.enable) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters, phase accumulator and divisor shadowing
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            os_cnt      <= '0;
            acc         <= '0;
            carry       <= 1'b0;
            tick_os_q   <= 1'b0;
            tick_bit_q  <= 1'b0;
            pending     <= 1'b0;
            upd         <= 1'b0;
            shadow_int  <= DIV_W'(DIV_INT_RST);
            shadow_frac <= FRAC_W'(DIV_FRAC_RST);
            act_int     <= DIV_W'(DIV_INT_RST);
            act_frac    <= FRAC_W'(DIV_FRAC_RST);
        end else begin
            tick_os_q  <= os_fire_c;
            tick_bit_q <= bit_fire_c;
            if (!bus.enable) begin
                cnt    <= '0;
                os_cnt <= '0;
                acc    <= '0;
                carry  <= 1'b0;
                upd    <= 1'b0;
            end else begin
                cnt <= os_fire_c ? CNT_W'(1) : cnt + CNT_W'(1);
                if (os_fire_c) begin
                    {carry, acc} <= acc_sum_c;
                    os_cnt       <= bit_fire_c ? '0 : os_cnt + OS_W'(1);
                end
                // A load landing on the bit tick itself waits for the next bit
                upd <= bit_fire_c && pending && !bus.div_load;
            end
            if (bus.div_load) begin
                shadow_int  <= load_int_c;
                shadow_frac <= bus.div_frac;
                pending     <= 1'b1;
            end else if (pending && (upd || !bus.enable)) begin
                act_int  <= shadow_int;
                act_frac <= shadow_frac;
                pending  <= 1'b0;
            end
        end
    end

    assign bus.tick_os     = tick_os_q;
    assign bus.tick_bit    = tick_bit_q;
    assign bus.div_pending = pending;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: long-run default rate on an OS=16 instance,
// table of timing scenarios (align, fraction, divisor reload, clamp, reset) on an OS=4 instance.
module tb_uart_baud_gen_frac;
    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    uart_baud_gen_frac_if #(.DIV_W(16), .FRAC_W(4)) b16 ();
    uart_baud_gen_frac_if #(.DIV_W(16), .FRAC_W(4)) b4 ();

    uart_baud_gen_frac #(.OS(16)) dut16 (.clock(clock), .reset(reset), .bus(b16));
    uart_baud_gen_frac #(.OS(4))  dut4  (.clock(clock), .reset(reset), .bus(b4));

    typedef struct {
        string        name;
        logic         prelude;
        logic         align;
        int           dint;
        int           dfrac;
        int           ld_cyc0;
        int           ld_int0;
        int           ld_cyc1;
        int           ld_int1;
        int           ncyc;
        logic [127:0] os_m;
        logic [127:0] bit_m;
        logic [127:0] pend_m;
    } scen_t;

    scen_t tbl [7];

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [127:0] every(input int first, input int step, input int last);
        logic [127:0] r;
        r = '0;
        for (int i = first; i <= last; i += step) r[7'(i)] = 1'b1;
        return r;
    endfunction

    function automatic logic [127:0] m8(input int a, input int b, input int c, input int d,
                                        input int e, input int f, input int g, input int h);
        logic [127:0] r;
        int v [8];
        v = '{a, b, c, d, e, f, g, h};
        r = '0;
        for (int k = 0; k < 8; k++) if (v[k] >= 0) r[7'(v[k])] = 1'b1;
        return r;
    endfunction

    // Programs the divisor while idle (if requested), then runs from cycle 0 and checks every cycle
    task automatic run_scen(input scen_t s);
        if (s.dint >= 0) begin
            @(negedge clock);
            b4.div_int  = 16'(s.dint);
            b4.div_frac = 4'(s.dfrac);
            b4.div_load = 1'b1;
            @(negedge clock);
            b4.div_load = 1'b0;
        end
        @(negedge clock);
        b4.align_half = s.align;
        for (int c = 0; c <= s.ncyc; c++) begin
            b4.enable   = 1'b1;
            b4.div_load = (c == s.ld_cyc0) || (c == s.ld_cyc1);
            b4.div_int  = 16'((c == s.ld_cyc1) ? s.ld_int1 : s.ld_int0);
            b4.div_frac = '0;
            @(posedge clock);
            #1;
            chk1($sformatf("%s_os@%0d", s.name, c), b4.tick_os, s.os_m[7'(c)]);
            chk1($sformatf("%s_bit@%0d", s.name, c), b4.tick_bit, s.bit_m[7'(c)]);
            chk1($sformatf("%s_pend@%0d", s.name, c), b4.div_pending, s.pend_m[7'(c)]);
            @(negedge clock);
        end
        b4.div_load = 1'b0;
    endtask

    initial begin
        int n;
        int last;
        int d;
        logic [127:0] re_m;

        vectors     = 0;
        miscompares = 0;

        tbl[0] = '{"s2_div4", 1'b0, 1'b0, 4, 0, -1, 0, -1, 0, 50,
                   every(4, 4, 48), every(16, 16, 48), '0};
        tbl[1] = '{"s3_half", 1'b0, 1'b1, 4, 0, -1, 0, -1, 0, 50,
                   every(4, 4, 48), every(8, 16, 40), '0};
        tbl[2] = '{"s4_frac", 1'b0, 1'b0, 4, 8, -1, 0, -1, 0, 33,
                   m8(4, 8, 13, 17, 22, 26, 31, -1), m8(17, -1, -1, -1, -1, -1, -1, -1), '0};
        tbl[3] = '{"s5_load", 1'b0, 1'b0, 4, 0, 10, 8, 48, 4, 90,
                   every(4, 4, 16) | every(24, 8, 80) | every(84, 4, 88),
                   m8(16, 48, 80, -1, -1, -1, -1, -1),
                   every(10, 1, 16) | every(48, 1, 80)};
        // After a mid-bit reset the power-on divisor 6 + 13/16 must be back in force
        tbl[4] = '{"s6_rst", 1'b1, 1'b0, -1, 0, -1, 0, -1, 0, 30,
                   m8(6, 12, 19, 26, -1, -1, -1, -1), m8(26, -1, -1, -1, -1, -1, -1, -1), '0};
        tbl[5] = '{"s7_int1", 1'b0, 1'b0, 1, 0, -1, 0, -1, 0, 20,
                   every(2, 2, 20), every(8, 8, 16), '0};
        tbl[6] = '{"s7_int0", 1'b0, 1'b0, 0, 0, -1, 0, -1, 0, 20,
                   every(2, 2, 20), every(8, 8, 16), '0};

        reset = 1'b1;
        b16.enable = 1'b0; b16.align_half = 1'b0; b16.div_int = '0; b16.div_frac = '0; b16.div_load = 1'b0;
        b4.enable  = 1'b0; b4.align_half  = 1'b0; b4.div_int  = '0; b4.div_frac  = '0; b4.div_load  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk1("rst_os16", b16.tick_os, 1'b0);
        chk1("rst_bit16", b16.tick_bit, 1'b0);
        chk1("rst_pend16", b16.div_pending, 1'b0);
        chk1("rst_os4", b4.tick_os, 1'b0);
        chk1("rst_bit4", b4.tick_bit, 1'b0);
        chk1("rst_pend4", b4.div_pending, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Default rate: tick n lands at 6n + floor(13(n-1)/16), bit tick on every 16th
        @(negedge clock);
        b16.enable = 1'b1;
        n    = 0;
        last = -1;
        for (int c = 0; c < 7200 && n < 1000; c++) begin
            @(posedge clock);
            #1;
            if (b16.tick_os) begin
                n++;
                last = c;
                chki($sformatf("t1_pos%0d", n), c, 6 * n + (13 * (n - 1)) / 16);
                chk1($sformatf("t1_bit%0d", n), b16.tick_bit, (n % 16) == 0);
            end else if (b16.tick_bit) begin
                chk1($sformatf("t1_bit_alone@%0d", c), b16.tick_bit, 1'b0);
            end
        end
        chki("t1_count", n, 1000);
        chki("t1_total", last, 6811);

        // Drop enable exactly where tick 1001 would have fired
        d = (6 * 1001 + (13 * 1000) / 16) - last;
        repeat (d - 1) @(posedge clock);
        @(negedge clock);
        b16.enable = 1'b0;
        @(posedge clock);
        #1;
        chk1("t6_drop_os", b16.tick_os, 1'b0);
        chk1("t6_drop_bit", b16.tick_bit, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        chk1("t6_idle_os", b16.tick_os, 1'b0);
        @(negedge clock);
        b16.enable = 1'b1;
        re_m = m8(6, 12, 19, -1, -1, -1, -1, -1);
        for (int c = 0; c <= 20; c++) begin
            @(posedge clock);
            #1;
            chk1($sformatf("t6_re_os@%0d", c), b16.tick_os, re_m[7'(c)]);
            chk1($sformatf("t6_re_bit@%0d", c), b16.tick_bit, 1'b0);
        end
        @(negedge clock);
        b16.enable = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].prelude) begin
                // Still enabled from the previous row: load, then reset on a cycle that would tick
                @(negedge clock);
                b4.div_int  = 16'd8;
                b4.div_load = 1'b1;
                @(posedge clock);
                #1;
                chk1("s6_pend_set", b4.div_pending, 1'b1);
                @(negedge clock);
                b4.div_load = 1'b0;
                reset       = 1'b1;
                @(posedge clock);
                #1;
                chk1("s6_rst_os", b4.tick_os, 1'b0);
                chk1("s6_rst_bit", b4.tick_bit, 1'b0);
                chk1("s6_rst_pend", b4.div_pending, 1'b0);
                @(negedge clock);
                reset     = 1'b0;
                b4.enable = 1'b0;
            end else begin
                @(negedge clock);
                reset     = 1'b1;
                b4.enable = 1'b0;
                repeat (2) @(posedge clock);
                @(negedge clock);
                reset = 1'b0;
            end
            run_scen(tbl[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
